// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, ALU and
// immediate encodings, datapath mux selects, FSM states and the ALU decode modes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WRITE, S_MEM_WB,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR_ADR, S_LUI
    } state_e;

    typedef enum logic [1:0] {
        ALU_MODE_ADD, ALU_MODE_SUB, ALU_MODE_FUNCT, ALU_MODE_BRANCH
    } alu_mode_e;

    // Immediate format implied by the opcode; I-type covers everything unlisted.
    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_decode.sv
// Combinational ALU operation decode.
//   mode        : forced ADD / SUB, funct3-driven, or branch compare
//   funct3      : IR[14:12]
//   funct7_b5   : IR[30], selects SUB for funct3=000 in FUNCT mode
//   alu_control : ALU operation code
module riscv_alu_decode
    import riscv_ctrl_pkg::*;
(
    input  alu_mode_e   mode,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (mode)
            ALU_MODE_ADD: alu_control = ALU_ADD;
            ALU_MODE_SUB: alu_control = ALU_SUB;
            ALU_MODE_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = funct7_b5 ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b100:  alu_control = ALU_XOR;
                    3'b010:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            // beq/bne compare by subtraction, blt/bge by set-less-than
            ALU_MODE_BRANCH: alu_control = funct3[2] ? ALU_SLT : ALU_SUB;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM driving a shared-memory registered datapath.
//   clk, rst_n            : clock, async active-low reset
//   op/funct3/funct7      : fields of the instruction register
//   zero                  : ALU zero flag (branch resolution)
//   mem_ready             : memory handshake, honoured only when MEM_WAIT=1
//   pc_write .. imm_src   : datapath enables and mux selects
//   instr_done, illegal   : retire pulse and unsupported-opcode pulse
//   instret               : retired-instruction counter
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3,
    parameter int unsigned IMM_SRC_W  = 3,
    parameter int unsigned MEM_WAIT   = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [IMM_SRC_W-1:0]  imm_src,
    output logic                  instr_done,
    output logic                  illegal,
    output logic [CNT_W-1:0]      instret
);

    state_e     state;
    state_e     state_nxt;
    alu_mode_e  alu_mode;
    logic       alu_f7b5;
    logic [2:0] alu_code;
    logic       ready_c;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // With MEM_WAIT=0 every memory state completes in a single cycle.
    assign ready_c = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    riscv_alu_decode u_alu_decode (
        .mode        (alu_mode),
        .funct3      (funct3),
        .funct7_b5   (alu_f7b5),
        .alu_control (alu_code)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore output decode; everything is forced low during reset.
    always_comb begin
        state_nxt  = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        imm_src    = '0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        alu_mode   = ALU_MODE_ADD;
        alu_f7b5   = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (ready_c) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut <- old-PC + imm, the branch/jump target
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_SRC_W'(imm_of(op));
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
                    OP_R:              state_nxt = S_EXEC_R;
                    OP_I:              state_nxt = S_EXEC_I;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR_ADR;
                    OP_LUI:            state_nxt = S_LUI;
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_SRC_W'(imm_of(op));
                state_nxt = (op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (ready_c) begin
                    state_nxt = S_MEM_WB;
                end
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ready_c) begin
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
            end
            S_MEM_WB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                alu_mode  = ALU_MODE_FUNCT;
                alu_f7b5  = funct7[5];
                state_nxt = S_ALU_WB;
            end
            S_EXEC_I: begin
                // funct7 is not forwarded: there is no SUBI
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_SRC_W'(IMM_I);
                alu_mode  = ALU_MODE_FUNCT;
                state_nxt = S_ALU_WB;
            end
            S_ALU_WB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_REG;
                alu_mode   = ALU_MODE_BRANCH;
                result_src = RES_ALUOUT;
                case (funct3)
                    3'b000:  pc_write = zero;
                    3'b001:  pc_write = !zero;
                    3'b100:  pc_write = !zero;
                    3'b101:  pc_write = zero;
                    default: pc_write = 1'b0;
                endcase
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JAL: begin
                // PC <- target in ALUOut while ALUOut <- old-PC + 4 for the link
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_nxt  = S_ALU_WB;
            end
            S_JALR_ADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_SRC_W'(IMM_I);
                state_nxt = S_JAL;
            end
            S_LUI: begin
                result_src = RES_IMM;
                imm_src    = IMM_SRC_W'(IMM_U);
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        if (!rst_n) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = '0;
            alu_src_a  = '0;
            alu_src_b  = '0;
            imm_src    = '0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign alu_control = rst_n ? ALU_CTRL_W'(alu_code) : '0;

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (instr_done) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: dut1 waits on mem_ready, dut2 ignores it and
// carries a 4-bit instret so the counter wrap is reachable.
module tb_riscv_multicycle_ctrl;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RR  = 7'b0110011;
    localparam logic [6:0] RI  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] LU  = 7'b0110111;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [2:0] imm_src;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t rdy;
        ctl_t wt;
        ctl_t care;
        bit   mem;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready1, mem_ready2;

    logic       pc_write1, adr_src1, mem_read1, mem_write1, ir_write1, reg_write1;
    logic [1:0] result_src1, alu_src_a1, alu_src_b1;
    logic [2:0] alu_control1, imm_src1;
    logic       instr_done1, illegal1;
    logic [31:0] instret1;

    logic       pc_write2, adr_src2, mem_read2, mem_write2, ir_write2, reg_write2;
    logic [1:0] result_src2, alu_src_a2, alu_src_b2;
    logic [2:0] alu_control2, imm_src2;
    logic       instr_done2, illegal2;
    logic [3:0] instret2;

    ctl_t w1, w2;
    assign w1 = {pc_write1, adr_src1, mem_read1, mem_write1, ir_write1, reg_write1,
                 result_src1, alu_src_a1, alu_src_b1, alu_control1, imm_src1,
                 instr_done1, illegal1};
    assign w2 = {pc_write2, adr_src2, mem_read2, mem_write2, ir_write2, reg_write2,
                 result_src2, alu_src_a2, alu_src_b2, alu_control2, imm_src2,
                 instr_done2, illegal2};

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(.ALU_CTRL_W(3), .IMM_SRC_W(3), .MEM_WAIT(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready1),
        .pc_write(pc_write1), .adr_src(adr_src1), .mem_read(mem_read1),
        .mem_write(mem_write1), .ir_write(ir_write1), .reg_write(reg_write1),
        .result_src(result_src1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
        .alu_control(alu_control1), .imm_src(imm_src1), .instr_done(instr_done1),
        .illegal(illegal1), .instret(instret1)
    );

    riscv_multicycle_ctrl #(.ALU_CTRL_W(3), .IMM_SRC_W(3), .MEM_WAIT(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready2),
        .pc_write(pc_write2), .adr_src(adr_src2), .mem_read(mem_read2),
        .mem_write(mem_write2), .ir_write(ir_write2), .reg_write(reg_write2),
        .result_src(result_src2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
        .alu_control(alu_control2), .imm_src(imm_src2), .instr_done(instr_done2),
        .illegal(illegal2), .instret(instret2)
    );

    int     total = 0;
    int     bad   = 0;
    int     cnt   = 0;
    entry_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [6:0] o);
        case (o)
            LD, ST, RR, RI, BR, JL, JR, LU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        case (o)
            ST:      return 3'b001;
            BR:      return 3'b010;
            JL:      return 3'b011;
            LU:      return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b100:  return 3'b100;
            3'b010:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic void add(input ctl_t r, input ctl_t w, input bit m, input ctl_t cr);
        entry_t e;
        e.rdy = r; e.wt = w; e.mem = m; e.care = cr;
        q.push_back(e);
    endfunction

    // Writeback cycle shared by R, I, jal and jalr.
    function automatic void add_wb();
        ctl_t c;
        c = '0; c.reg_write = 1'b1; c.instr_done = 1'b1;
        add(c, c, 1'b0, '1);
    endfunction

    function automatic void add_jal();
        ctl_t c;
        c = '0; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
        add(c, c, 1'b0, '1);
    endfunction

    // Per-cycle expected control words of one instruction; returns whether it retires.
    function automatic bit build(input logic [6:0] o, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z);
        ctl_t c, d, cr;
        q.delete();
        c = '0; c.mem_read = 1'b1; c.result_src = 2'b10; c.alu_src_b = 2'b10;
        d = c; d.ir_write = 1'b1; d.pc_write = 1'b1;
        add(d, c, 1'b1, '1);
        c = '0; c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = exp_imm(o);
        c.illegal = !legal(o);
        add(c, c, 1'b0, '1);
        if (!legal(o)) return 1'b0;
        case (o)
            LD, ST: begin
                c = '0; c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.imm_src = exp_imm(o);
                add(c, c, 1'b0, '1);
                if (o == LD) begin
                    c = '0; c.adr_src = 1'b1; c.mem_read = 1'b1;
                    add(c, c, 1'b1, '1);
                    c = '0; c.result_src = 2'b01; c.reg_write = 1'b1; c.instr_done = 1'b1;
                    add(c, c, 1'b0, '1);
                end else begin
                    c = '0; c.adr_src = 1'b1; c.mem_write = 1'b1;
                    d = c; d.instr_done = 1'b1;
                    add(d, c, 1'b1, '1);
                end
            end
            RR: begin
                c = '0; c.alu_src_a = 2'b10; c.alu_control = alu_of(f3, f7[5]);
                add(c, c, 1'b0, '1);
                add_wb();
            end
            RI: begin
                c = '0; c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_control = alu_of(f3, 1'b0);
                add(c, c, 1'b0, '1);
                add_wb();
            end
            BR: begin
                c = '0; c.alu_src_a = 2'b10; c.instr_done = 1'b1; cr = '1;
                case (f3)
                    3'b000: begin c.alu_control = 3'b001; c.pc_write = z;  end
                    3'b001: begin c.alu_control = 3'b001; c.pc_write = !z; end
                    3'b100: begin c.alu_control = 3'b101; c.pc_write = !z; end
                    3'b101: begin c.alu_control = 3'b101; c.pc_write = z;  end
                    default: cr.alu_control = 3'b000;
                endcase
                add(c, c, 1'b0, cr);
            end
            JL: begin
                add_jal();
                add_wb();
            end
            JR: begin
                c = '0; c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                add(c, c, 1'b0, '1);
                add_jal();
                add_wb();
            end
            default: begin
                c = '0; c.result_src = 2'b11; c.imm_src = 3'b100;
                c.reg_write = 1'b1; c.instr_done = 1'b1;
                add(c, c, 1'b0, '1);
            end
        endcase
        return 1'b1;
    endfunction

    // Runs one instruction from FETCH; fs/ms are stall cycles in FETCH / data memory
    // state (dut1 only), zf<0 picks a random zero flag.
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input int zf, input int fs, input int ms, input bit chk2);
        bit   ret;
        logic z;
        int   st;
        z = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
        op = o; funct3 = f3; funct7 = f7; zero = z;
        ret = build(o, f3, f7, z);
        for (int i = 0; i < q.size(); i++) begin
            st = q[i].mem ? ((i == 0) ? fs : ms) : 0;
            for (int k = 0; k < st; k++) begin
                mem_ready1 = 1'b0;
                mem_ready2 = 1'($urandom_range(0, 1));
                @(negedge clk);
                check($sformatf("wait op=%b f3=%b cyc=%0d", o, f3, i),
                      32'(w1 & q[i].care), 32'(q[i].wt & q[i].care));
                @(posedge clk); #1;
            end
            mem_ready1 = q[i].mem ? 1'b1 : 1'($urandom_range(0, 1));
            mem_ready2 = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("ctl op=%b f3=%b z=%b cyc=%0d", o, f3, z, i),
                  32'(w1 & q[i].care), 32'(q[i].rdy & q[i].care));
            if (chk2)
                check($sformatf("ctl_nowait op=%b f3=%b z=%b cyc=%0d", o, f3, z, i),
                      32'(w2 & q[i].care), 32'(q[i].rdy & q[i].care));
            @(posedge clk); #1;
        end
        if (ret) cnt++;
        check("instret", instret1, 32'(cnt));
        if (chk2) check("instret_wrap", 32'(instret2), 32'(cnt % 16));
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_ctl"}, 32'(w1), 32'd0);
        check({tag, "_ctl_nowait"}, 32'(w2), 32'd0);
        check({tag, "_instret"}, instret1, 32'd0);
        check({tag, "_instret_nowait"}, 32'(instret2), 32'd0);
    endtask

    // Random instruction with a legal funct3 for its class.
    task automatic run_rand(input bit stalls, input bit chk2);
        logic [2:0] f3tab[5];
        logic [2:0] brtab[4];
        logic [6:0] o;
        logic [2:0] f3;
        int         k;
        f3tab = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
        brtab = '{3'b000, 3'b001, 3'b100, 3'b101};
        k  = $urandom_range(0, 8);
        f3 = 3'($urandom);
        case (k)
            0: o = LD;
            1: o = ST;
            2: begin o = RR; f3 = f3tab[$urandom_range(0, 4)]; end
            3: begin o = RI; f3 = f3tab[$urandom_range(0, 4)]; end
            4: begin o = BR; f3 = brtab[$urandom_range(0, 3)]; end
            5: o = JL;
            6: o = JR;
            7: o = LU;
            default: begin
                o = 7'($urandom);
                if (legal(o)) o = 7'b1111111;
            end
        endcase
        run(o, f3, 7'($urandom), -1,
            stalls ? $urandom_range(0, 2) : 0, stalls ? $urandom_range(0, 2) : 0, chk2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] brtab[4];
        brtab = '{3'b000, 3'b001, 3'b100, 3'b101};
        rst_n = 1'b0; op = '0; funct3 = '0; funct7 = '0; zero = 1'b0;
        mem_ready1 = 1'b0; mem_ready2 = 1'b0;
        #1;
        reset_check("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed, both DUTs in lock step.
        run(RR, 3'b000, 7'b0000000, -1, 0, 0, 1'b1);
        run(RR, 3'b000, 7'b0100000, -1, 0, 0, 1'b1);
        run(RR, 3'b111, 7'b0000000, -1, 0, 0, 1'b1);
        run(RR, 3'b010, 7'b0100000, -1, 0, 0, 1'b1);
        run(RI, 3'b000, 7'b0100000, -1, 0, 0, 1'b1);
        run(RI, 3'b100, 7'b0000000, -1, 0, 0, 1'b1);
        run(LD, 3'b010, 7'b0000000, -1, 0, 0, 1'b1);
        run(ST, 3'b010, 7'b0000000, -1, 0, 0, 1'b1);
        foreach (brtab[i]) begin
            run(BR, brtab[i], 7'b0, 1, 0, 0, 1'b1);
            run(BR, brtab[i], 7'b0, 0, 0, 0, 1'b1);
        end
        run(BR, 3'b010, 7'b0, 1, 0, 0, 1'b1);
        run(BR, 3'b111, 7'b0, 0, 0, 0, 1'b1);
        run(JR, 3'b000, 7'b0, -1, 0, 0, 1'b1);
        run(LU, 3'b000, 7'b0, -1, 0, 0, 1'b1);
        run(JL, 3'b000, 7'b0, -1, 0, 0, 1'b1);
        run(7'b0000000, 3'b000, 7'b0, -1, 0, 0, 1'b1);
        repeat (30) run_rand(1'b0, 1'b1);

        // Memory stalls on the waiting DUT only.
        run(LD, 3'b010, 7'b0, -1, 2, 1, 1'b0);
        run(ST, 3'b010, 7'b0, -1, 1, 2, 1'b0);
        repeat (20) run_rand(1'b1, 1'b0);

        // Reset in the middle of a load.
        op = LD; mem_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 reset_check("midrst");
        @(posedge clk); #1;
        reset_check("inrst");
        rst_n = 1'b1;
        cnt = 0;
        run(RR, 3'b110, 7'b0, -1, 0, 0, 1'b1);
        run(LU, 3'b000, 7'b0, -1, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
